// File: rtl/fetch_seq_if.sv
// Command, load-stream and fetch-control bundle between the debug front end,
// the fetch stage / imem write port (master side) and fetch_sequencer (slave side).
interface fetch_seq_if #(
    parameter int IMEM_ADDR_W = 8
);
    logic                   i_cmd_valid;
    logic [2:0]             i_cmd;
    logic                   i_byte_valid;
    logic [7:0]             i_byte;
    logic                   i_halt_retired;
    logic                   i_stall;
    logic                   o_cmd_ready;
    logic                   o_valid;
    logic                   o_pc_reset;
    logic                   o_imem_we;
    logic [IMEM_ADDR_W-1:0] o_imem_addr;
    logic [31:0]            o_imem_data;
    logic [2:0]             o_state;
    logic [31:0]            o_cycle_cnt;
    logic                   o_timeout;

    modport slave (
        input  i_cmd_valid, i_cmd, i_byte_valid, i_byte, i_halt_retired, i_stall,
        output o_cmd_ready, o_valid, o_pc_reset, o_imem_we, o_imem_addr, o_imem_data,
               o_state, o_cycle_cnt, o_timeout
    );

    modport master (
        output i_cmd_valid, i_cmd, i_byte_valid, i_byte, i_halt_retired, i_stall,
        input  o_cmd_ready, o_valid, o_pc_reset, o_imem_we, o_imem_addr, o_imem_data,
               o_state, o_cycle_cnt, o_timeout
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch-stage run controller: loads imem from a byte stream, then runs or single-steps
// the fetch stage until halt retires. Define FETCH_SEQ_WATCHDOG_EN for the run watchdog.
module fetch_sequencer #(
    parameter int          IMEM_ADDR_W = 8,
    parameter logic [31:0] HALT_WORD   = 32'hFFFF_FFFF,
    parameter int          WDOG_CYCLES = 1024
) (
    input logic        i_clk,
    input logic        i_reset,
    fetch_seq_if.slave bus
);
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_RUN       = 3'd2,
        ST_STEP_WAIT = 3'd3,
        ST_STEP      = 3'd4,
        ST_HALTED    = 3'd5
    } state_e;

    localparam logic [2:0] CMD_LOAD      = 3'd1;
    localparam logic [2:0] CMD_RUN       = 3'd2;
    localparam logic [2:0] CMD_STEP_MODE = 3'd3;
    localparam logic [2:0] CMD_STEP      = 3'd4;
    localparam logic [2:0] CMD_STOP      = 3'd5;
    localparam logic [2:0] CMD_CLEAR     = 3'd6;
    localparam logic [IMEM_ADDR_W-1:0] ADDR_LAST = {IMEM_ADDR_W{1'b1}};

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    state_e                 state_q, state_d;
    logic [1:0]             byte_idx_q, byte_idx_d;
    logic [23:0]            word_q, word_d;
    logic [31:0]            data_q, data_d;
    logic                   we_q, we_d;
    logic [IMEM_ADDR_W-1:0] addr_q, addr_d;
    logic                   pc_reset_q, pc_reset_d;
    logic                   valid_q, valid_d;
    logic                   cmd_ready_q, cmd_ready_d;
    logic [31:0]            cycle_cnt_q, cycle_cnt_d;

    logic cmd_acc_s;
    logic load_s, run_s, step_mode_s, step_s, stop_s, clear_s;
    logic wdog_fire_s;

    // Command acceptance: STOP is additionally taken while busy in RUN or LOAD.
    always_comb begin
        cmd_acc_s = bus.i_cmd_valid &&
                    (cmd_ready_q ||
                     ((bus.i_cmd == CMD_STOP) && ((state_q == ST_RUN) || (state_q == ST_LOAD))));
        load_s      = cmd_acc_s && (bus.i_cmd == CMD_LOAD);
        run_s       = cmd_acc_s && (bus.i_cmd == CMD_RUN);
        step_mode_s = cmd_acc_s && (bus.i_cmd == CMD_STEP_MODE);
        step_s      = cmd_acc_s && (bus.i_cmd == CMD_STEP);
        stop_s      = cmd_acc_s && (bus.i_cmd == CMD_STOP);
        clear_s     = cmd_acc_s && (bus.i_cmd == CMD_CLEAR);
    end

`ifdef FETCH_SEQ_WATCHDOG_EN
    localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);

    logic [WDOG_W-1:0] wdog_q, wdog_d;
    logic              timeout_q, timeout_d;

    // Watchdog: counts RUN cycles since entry; sticky timeout until a restarting command.
    always_comb begin
        wdog_fire_s = (state_q == ST_RUN) && (wdog_q == WDOG_LAST) && !bus.i_halt_retired;
        if (state_q == ST_RUN) begin
            wdog_d = wdog_q + WDOG_W'(1);
        end else begin
            wdog_d = '0;
        end
        if (wdog_fire_s) begin
            timeout_d = 1'b1;
        end else if (load_s || run_s || step_mode_s || clear_s) begin
            timeout_d = 1'b0;
        end else begin
            timeout_d = timeout_q;
        end
    end

    // Watchdog registers.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            wdog_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            wdog_q    <= wdog_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.o_timeout = timeout_q;
`else
    logic unused_wdog_s;
    assign unused_wdog_s = (WDOG_CYCLES == 32'sd0);
    assign wdog_fire_s   = 1'b0;
    assign bus.o_timeout = 1'b0;
`endif

    // Next-state, byte assembler, write strobe and cycle counter.
    always_comb begin
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        word_d     = word_q;
        data_d     = data_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        pc_reset_d = 1'b0;
        if (valid_q && !bus.i_stall) begin
            cycle_cnt_d = sat_inc32(cycle_cnt_q);
        end else begin
            cycle_cnt_d = cycle_cnt_q;
        end

        case (state_q)
            ST_IDLE, ST_HALTED: begin
                if (load_s) begin
                    state_d    = ST_LOAD;
                    addr_d     = '0;
                    byte_idx_d = 2'd0;
                    word_d     = 24'd0;
                end else if (run_s) begin
                    state_d     = ST_RUN;
                    pc_reset_d  = 1'b1;
                    cycle_cnt_d = 32'd0;
                end else if (step_mode_s) begin
                    state_d     = ST_STEP_WAIT;
                    pc_reset_d  = 1'b1;
                    cycle_cnt_d = 32'd0;
                end else if (clear_s) begin
                    state_d    = ST_IDLE;
                    pc_reset_d = (state_q == ST_IDLE);
                end else begin
                    state_d = state_q;
                end
            end
            ST_LOAD: begin
                if (stop_s) begin
                    state_d    = ST_IDLE;
                    byte_idx_d = 2'd0;
                end else begin
                    // The write cycle retires the word; address saturates at the last entry.
                    if (we_q) begin
                        if ((data_q == HALT_WORD) || (addr_q == ADDR_LAST)) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_LOAD;
                        end
                        if (addr_q != ADDR_LAST) begin
                            addr_d = addr_q + IMEM_ADDR_W'(1);
                        end else begin
                            addr_d = addr_q;
                        end
                    end else begin
                        state_d = ST_LOAD;
                    end
                    if (bus.i_byte_valid) begin
                        byte_idx_d = byte_idx_q + 2'd1;
                        case (byte_idx_q)
                            2'd0:    word_d[7:0]   = bus.i_byte;
                            2'd1:    word_d[15:8]  = bus.i_byte;
                            2'd2:    word_d[23:16] = bus.i_byte;
                            2'd3: begin
                                data_d = {bus.i_byte, word_q};
                                we_d   = 1'b1;
                            end
                            default: word_d = word_q;
                        endcase
                    end else begin
                        byte_idx_d = byte_idx_q;
                    end
                end
            end
            ST_RUN: begin
                if (bus.i_halt_retired || wdog_fire_s) begin
                    state_d = ST_HALTED;
                end else if (stop_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_STEP_WAIT: begin
                if (bus.i_halt_retired) begin
                    state_d = ST_HALTED;
                end else if (step_s) begin
                    state_d = ST_STEP;
                end else if (stop_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_STEP_WAIT;
                end
            end
            ST_STEP: begin
                if (bus.i_halt_retired) begin
                    state_d = ST_HALTED;
                end else if (!bus.i_stall) begin
                    state_d = ST_STEP_WAIT;
                end else begin
                    state_d = ST_STEP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        valid_d     = (state_d == ST_RUN) || (state_d == ST_STEP);
        cmd_ready_d = (state_d == ST_IDLE) || (state_d == ST_STEP_WAIT) || (state_d == ST_HALTED);
    end

    // State and output registers.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q     <= ST_IDLE;
            byte_idx_q  <= 2'd0;
            word_q      <= 24'd0;
            data_q      <= 32'd0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            pc_reset_q  <= 1'b0;
            valid_q     <= 1'b0;
            cmd_ready_q <= 1'b1;
            cycle_cnt_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            byte_idx_q  <= byte_idx_d;
            word_q      <= word_d;
            data_q      <= data_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            pc_reset_q  <= pc_reset_d;
            valid_q     <= valid_d;
            cmd_ready_q <= cmd_ready_d;
            cycle_cnt_q <= cycle_cnt_d;
        end
    end

    assign bus.o_cmd_ready = cmd_ready_q;
    assign bus.o_valid     = valid_q;
    assign bus.o_pc_reset  = pc_reset_q;
    assign bus.o_imem_we   = we_q;
    assign bus.o_imem_addr = addr_q;
    assign bus.o_imem_data = data_q;
    assign bus.o_state     = state_q;
    assign bus.o_cycle_cnt = cycle_cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: stimulus queues expected imem writes, o_valid
// burst lengths and o_pc_reset pulse widths; a negedge monitor pops and compares them.
module tb_fetch_sequencer;
    localparam logic [2:0] C_LOAD = 3'd1, C_RUN = 3'd2, C_STEP_MODE = 3'd3;
    localparam logic [2:0] C_STEP = 3'd4, C_STOP = 3'd5, C_CLEAR = 3'd6;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    logic [39:0] exp_wr_q[$];
    int          exp_burst_q[$];
    int          exp_pulse_q[$];
    int          vcnt = 0;
    int          pcnt = 0;

    fetch_seq_if #(.IMEM_ADDR_W(8)) bus ();

    fetch_sequencer #(
        .IMEM_ADDR_W(8),
        .HALT_WORD  (32'hFFFF_FFFF),
        .WDOG_CYCLES(16)
    ) dut (
        .i_clk  (clk),
        .i_reset(rst_n),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [2:0] c);
        bus.i_cmd_valid = 1'b1;
        bus.i_cmd       = c;
        tick();
        bus.i_cmd_valid = 1'b0;
        bus.i_cmd       = 3'd0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.i_byte_valid = 1'b1;
        bus.i_byte       = b;
        tick();
        bus.i_byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[7:0]);
        send_byte(w[15:8]);
        send_byte(w[23:16]);
        send_byte(w[31:24]);
    endtask

    // Monitor: compares every write, every o_valid burst and every o_pc_reset pulse.
    always @(negedge clk) begin
        if (!rst_n) begin
            vcnt = 0;
            pcnt = 0;
        end else begin
            if (bus.o_imem_we) begin
                check("wr_expected", 64'(exp_wr_q.size() != 0), 64'd1);
                if (exp_wr_q.size() != 0)
                    check("wr_addr_data", 64'({bus.o_imem_addr, bus.o_imem_data}),
                          64'(exp_wr_q.pop_front()));
                check("wr_in_load", 64'(bus.o_state), 64'd1);
            end
            if (bus.o_valid) begin
                vcnt++;
            end else if (vcnt != 0) begin
                check("burst_expected", 64'(exp_burst_q.size() != 0), 64'd1);
                if (exp_burst_q.size() != 0)
                    check("valid_burst_len", 64'(vcnt), 64'(exp_burst_q.pop_front()));
                vcnt = 0;
            end
            if (bus.o_pc_reset) begin
                pcnt++;
            end else if (pcnt != 0) begin
                check("pc_pulse_expected", 64'(exp_pulse_q.size() != 0), 64'd1);
                if (exp_pulse_q.size() != 0)
                    check("pc_pulse_len", 64'(pcnt), 64'(exp_pulse_q.pop_front()));
                pcnt = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL sim_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] w;
        rst_n              = 1'b0;
        bus.i_cmd_valid    = 1'b0;
        bus.i_cmd          = 3'd0;
        bus.i_byte_valid   = 1'b0;
        bus.i_byte         = 8'd0;
        bus.i_halt_retired = 1'b0;
        bus.i_stall        = 1'b0;
        #22 rst_n = 1'b1;
        @(negedge clk);
        check("rst_state", 64'(bus.o_state), 64'd0);
        check("rst_cmd_ready", 64'(bus.o_cmd_ready), 64'd1);
        check("rst_outputs", 64'({bus.o_valid, bus.o_pc_reset, bus.o_imem_we, bus.o_timeout}), 64'd0);
        check("rst_cycle_cnt", 64'(bus.o_cycle_cnt), 64'd0);

        // Two-word load terminated by the halt word; 5th byte lands in the write cycle.
        exp_wr_q.push_back({8'h00, 32'h1234_5678});
        exp_wr_q.push_back({8'h01, 32'hFFFF_FFFF});
        send_cmd(C_LOAD);
        @(negedge clk);
        check("load_cmd_ready", 64'(bus.o_cmd_ready), 64'd0);
        send_word(32'h1234_5678);
        send_word(32'hFFFF_FFFF);
        repeat (2) tick();
        @(negedge clk);
        check("load_done_state", 64'(bus.o_state), 64'd0);
        check("load_done_ready", 64'(bus.o_cmd_ready), 64'd1);

        // RUN with a 3-cycle stall, halt retiring in cycle 10.
        exp_pulse_q.push_back(1);
        exp_burst_q.push_back(10);
        send_cmd(C_RUN);
        for (int k = 1; k <= 10; k++) begin
            bus.i_stall        = (k >= 2) && (k <= 4);
            bus.i_halt_retired = (k == 10);
            tick();
        end
        bus.i_stall        = 1'b0;
        bus.i_halt_retired = 1'b0;
        @(negedge clk);
        check("run_halted_state", 64'(bus.o_state), 64'd5);
        check("run_valid_off", 64'(bus.o_valid), 64'd0);
        check("run_cycle_cnt", 64'(bus.o_cycle_cnt), 64'd7);
        repeat (3) tick();
        check("halted_cnt_frozen", 64'(bus.o_cycle_cnt), 64'd7);

        // Single-step: three steps, the second stalled for two cycles.
        exp_pulse_q.push_back(1);
        send_cmd(C_STEP_MODE);
        @(negedge clk);
        check("stepmode_state", 64'(bus.o_state), 64'd3);
        check("stepmode_cnt_clr", 64'(bus.o_cycle_cnt), 64'd0);
        exp_burst_q.push_back(1);
        exp_burst_q.push_back(3);
        exp_burst_q.push_back(1);
        for (int s = 0; s < 3; s++) begin
            send_cmd(C_STEP);
            if (s == 1) begin
                bus.i_stall = 1'b1;
                repeat (2) tick();
                bus.i_stall = 1'b0;
            end
            repeat (4) tick();
        end
        @(negedge clk);
        check("step_cycle_cnt", 64'(bus.o_cycle_cnt), 64'd3);
        check("step_wait_state", 64'(bus.o_state), 64'd3);
        send_cmd(C_STOP);
        @(negedge clk);
        check("stepwait_stop", 64'(bus.o_state), 64'd0);

        // STOP after two bytes discards the partial word; reload starts fresh.
        send_cmd(C_LOAD);
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_cmd(C_STOP);
        repeat (2) tick();
        check("load_stop_state", 64'(bus.o_state), 64'd0);
        exp_wr_q.push_back({8'h00, 32'h4433_2211});
        send_cmd(C_LOAD);
        send_word(32'h4433_2211);
        repeat (2) tick();
        check("reload_still_load", 64'(bus.o_state), 64'd1);
        send_cmd(C_STOP);
        check("reload_stop", 64'(bus.o_state), 64'd0);

        // STOP on the first RUN cycle.
        exp_pulse_q.push_back(1);
        exp_burst_q.push_back(1);
        send_cmd(C_RUN);
        send_cmd(C_STOP);
        @(negedge clk);
        check("run_stop_state", 64'(bus.o_state), 64'd0);

        // STOP coincident with halt: halt wins.
        exp_pulse_q.push_back(1);
        exp_burst_q.push_back(3);
        send_cmd(C_RUN);
        repeat (2) tick();
        bus.i_halt_retired = 1'b1;
        send_cmd(C_STOP);
        bus.i_halt_retired = 1'b0;
        @(negedge clk);
        check("stop_halt_state", 64'(bus.o_state), 64'd5);
        send_cmd(C_CLEAR);
        @(negedge clk);
        check("halted_clear", 64'(bus.o_state), 64'd0);
        exp_pulse_q.push_back(1);
        send_cmd(C_CLEAR);
        @(negedge clk);
        check("idle_clear_state", 64'(bus.o_state), 64'd0);

        // Full-depth load: ends at the last address without wrapping.
        send_cmd(C_LOAD);
        for (int i = 0; i < 256; i++) begin
            w = {8'hA5, 8'(i), ~8'(i), 8'(i)};
            exp_wr_q.push_back({8'(i), w});
            send_word(w);
        end
        repeat (2) tick();
        @(negedge clk);
        check("full_load_state", 64'(bus.o_state), 64'd0);
        check("full_load_addr", 64'(bus.o_imem_addr), 64'hFF);

`ifdef FETCH_SEQ_WATCHDOG_EN
        exp_pulse_q.push_back(1);
        exp_burst_q.push_back(16);
        send_cmd(C_RUN);
        repeat (20) tick();
        check("wdog_state", 64'(bus.o_state), 64'd5);
        check("wdog_timeout", 64'(bus.o_timeout), 64'd1);
        exp_pulse_q.push_back(1);
        exp_burst_q.push_back(1);
        send_cmd(C_RUN);
        @(negedge clk);
        check("wdog_cleared", 64'(bus.o_timeout), 64'd0);
        send_cmd(C_STOP);
`else
        exp_pulse_q.push_back(1);
        exp_burst_q.push_back(40);
        send_cmd(C_RUN);
        repeat (39) tick();
        @(negedge clk);
        check("long_run_state", 64'(bus.o_state), 64'd2);
        check("long_run_no_timeout", 64'(bus.o_timeout), 64'd0);
        send_cmd(C_STOP);
`endif
        repeat (2) tick();

        // Asynchronous reset mid-RUN, away from any clock edge.
        exp_pulse_q.push_back(1);
        send_cmd(C_RUN);
        repeat (5) tick();
        #3 rst_n = 1'b0;
        #1;
        check("arst_state", 64'(bus.o_state), 64'd0);
        check("arst_cmd_ready", 64'(bus.o_cmd_ready), 64'd1);
        check("arst_ctrl", 64'({bus.o_valid, bus.o_pc_reset, bus.o_imem_we, bus.o_timeout}), 64'd0);
        check("arst_cnt_addr", 64'({bus.o_cycle_cnt, bus.o_imem_addr}), 64'd0);
        check("arst_data", 64'(bus.o_imem_data), 64'd0);
        #2 rst_n = 1'b1;
        repeat (3) tick();

        check("wr_queue_empty", 64'(exp_wr_q.size()), 64'd0);
        check("burst_queue_empty", 64'(exp_burst_q.size()), 64'd0);
        check("pulse_queue_empty", 64'(exp_pulse_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Run controller for the MIPS pipeline's fetch stage.
- Loads a program into instruction memory from a byte stream.
- Then drives the fetch stage's valid/enable in continuous-run or single-step mode until the halt instruction retires.
- Sits between the debug/UART command front end and the fetch stage plus instruction memory write port.

Parameters:
IMEM_ADDR_W, 8, instruction memory word-address width (depth = 2**IMEM_ADDR_W words)
HALT_WORD, 32'hFFFF_FFFF, instruction encoding that terminates a program load
WDOG_CYCLES, 1024, run-mode watchdog limit (used only with the optional feature)

Ports:
i_clk  in  1  system clock, rising edge
i_reset  in  1  asynchronous, active-low reset
i_cmd_valid  in  1  command strobe, one cycle
i_cmd  in  3  1=LOAD 2=RUN 3=STEP_MODE 4=STEP 5=STOP 6=CLEAR; others ignored
i_byte_valid  in  1  load byte strobe
i_byte  in  8  load byte, little-endian within word
i_halt_retired  in  1  halt instruction reached writeback (pipeline drained)
i_stall  in  1  hazard stall from the hazard unit
o_cmd_ready  out  1  high when a new command is accepted
o_valid  out  1  fetch enable to the fetch stage
o_pc_reset  out  1  one-cycle pulse clearing the PC
o_imem_we  out  1  instruction memory write enable
o_imem_addr  out  IMEM_ADDR_W  instruction memory word address
o_imem_data  out  32  instruction memory write data
o_state  out  3  0=IDLE 1=LOAD 2=RUN 3=STEP_WAIT 4=STEP 5=HALTED
o_cycle_cnt  out  32  count of cycles with o_valid=1 and i_stall=0 since the last RUN/STEP_MODE entry
o_timeout  out  1  watchdog fired (tied 0 without the feature)

Behaviour:
Reset (i_reset=0, asynchronous):
- State IDLE.
- All outputs 0, except o_cmd_ready=1.
- Byte assembler and address cleared.

Command acceptance:
- A command is accepted only when i_cmd_valid=1 and o_cmd_ready=1.
- o_cmd_ready=1 in IDLE, STEP_WAIT and HALTED; 0 otherwise.
- Exception: STOP is also accepted in RUN and LOAD.

IDLE:
- LOAD -> LOAD; address cleared and byte index cleared.
- RUN -> RUN. STEP_MODE -> STEP_WAIT.
- Both RUN and STEP_MODE assert o_pc_reset for 1 cycle (the entry cycle) and clear o_cycle_cnt.
- CLEAR pulses o_pc_reset and stays in IDLE.

LOAD:
- Each i_byte_valid shifts a byte into the word: byte 0 -> bits[7:0], through byte 3 -> bits[31:24].
- On the 4th byte, the next cycle has o_imem_we=1 for exactly 1 cycle, carrying o_imem_data=word and o_imem_addr=current address. The address then increments.
- If the written word == HALT_WORD, or the address was 2**IMEM_ADDR_W-1, go to IDLE after the write. The address does not wrap.
- A byte arriving during the write cycle is accepted as byte 0 of the next word.
- STOP -> IDLE. A partial word is discarded and no write occurs.

RUN:
- o_valid=1 every cycle.
- o_cycle_cnt increments when i_stall=0. The counter saturates at 32'hFFFF_FFFF.
- i_halt_retired -> HALTED; o_valid=0 from the next cycle.
- STOP -> IDLE.

STEP_WAIT:
- o_valid=0.
- STEP -> STEP. STOP -> IDLE. i_halt_retired -> HALTED.

STEP:
- o_valid=1 for exactly one cycle, then STEP_WAIT.
- If i_stall=1 in that cycle, stay in STEP (o_valid held) until a cycle with i_stall=0. Exactly one unstalled advance happens per STEP command.

HALTED:
- o_valid=0; o_cycle_cnt frozen.
- LOAD, RUN and STEP_MODE behave as in IDLE. CLEAR -> IDLE.

Simultaneous events:
- i_halt_retired and STOP in the same cycle: halt wins -> HALTED.
- Reset mid-load: the partially loaded memory contents are kept; the block returns to IDLE.
- o_imem_we is never high outside LOAD.

Optional Feature:
Macro: FETCH_SEQ_WATCHDOG_EN.
With the macro defined:
- A counter counts RUN cycles since RUN entry.
- On reaching WDOG_CYCLES without i_halt_retired, go to HALTED with o_valid=0 and o_timeout=1.
- o_timeout holds until the next accepted RUN, STEP_MODE, LOAD or CLEAR command.
Without the macro:
- No counter is built; o_timeout is constant 0.
- RUN lasts until halt or STOP.

Test Plan:
- Reset, then LOAD plus bytes 78,56,34,12,FF,FF,FF,FF -> two writes: addr0=32'h12345678, addr1=32'hFFFFFFFF; state returns to IDLE; o_cmd_ready=1.
- RUN, stall held 3 cycles, halt_retired at cycle 10 -> 1-cycle o_pc_reset, o_valid high 10 cycles, o_cycle_cnt=7, state HALTED, o_valid=0.
- STEP_MODE, three STEP commands spaced 5 cycles apart, one stalled for 2 cycles -> three o_valid bursts of 1,3,1 cycles; o_cycle_cnt=3.
- STOP during LOAD after 2 bytes -> no o_imem_we; IDLE. STOP in RUN coincident with halt_retired -> HALTED.
- i_reset=0 asserted mid-RUN, not on a clock edge -> all outputs 0 immediately (o_cmd_ready=1); state IDLE.
- With FETCH_SEQ_WATCHDOG_EN defined and WDOG_CYCLES=16, RUN with no halt -> HALTED after 16 cycles, o_timeout=1; the next RUN clears it.
